// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, last legal opcode and FSM state type shared by alu_seq and its bench
package alu_pkg;
  localparam logic [3:0] OP_ROL = 4'd0;
  localparam logic [3:0] OP_SLL = 4'd1;
  localparam logic [3:0] OP_ROR = 4'd2;
  localparam logic [3:0] OP_SRA = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_LAST_LEGAL = OP_MUL;
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier (ports: i_start latches operands, i_step runs one partial product, o_done on last step, o_prod running/final product)
module alu_mul_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);
  logic [WIDTH-1:0] r_a, r_b;
  logic [2*WIDTH-1:0] r_acc, w_pp, w_acc_next;
  logic [SHW-1:0] r_cnt;
  assign w_pp = r_a[r_cnt] ? {{WIDTH{1'b0}}, r_b} << r_cnt : '0;
  assign w_acc_next = r_acc + w_pp;
  assign o_done = i_step && (r_cnt == SHW'(WIDTH - 1));
  assign o_prod = i_step ? w_acc_next : r_acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a <= i_a;
      r_b <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU (in_valid/in_ready/a/b/cin/op/inv_a/inv_b/sign in; out_valid/out_ready/out/ofl/zero/err registered out)
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       op,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ofl,
  output logic             zero,
  output logic             err
);
  state_t r_state;
  logic [WIDTH-1:0] w_a, w_b, w_res, r_out;
  logic [SHW-1:0] w_sh;
  logic [WIDTH:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic w_ofl, w_drain_ok, w_accept, w_start, w_done, w_load_alu, w_load_mul;
  logic r_out_valid, r_ofl, r_zero, r_err;
  assign w_a = inv_a ? ~a : a;
  assign w_b = inv_b ? ~b : b;
  assign w_sh = w_b[SHW-1:0];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, cin};
  always_comb begin
    w_res = '0;
    w_ofl = 1'b0;
    case (op)
      OP_ROL: w_res = (w_a << w_sh) | (w_a >> (WIDTH - int'(w_sh)));
      OP_SLL: w_res = w_a << w_sh;
      OP_ROR: w_res = (w_a >> w_sh) | (w_a << (WIDTH - int'(w_sh)));
      OP_SRA: w_res = $signed(w_a) >>> w_sh;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_ofl = sign ? (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]) : w_sum[WIDTH];
      end
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_AND: w_res = w_a & w_b;
      default: w_res = '0;
    endcase
  end
  assign w_drain_ok = !r_out_valid || out_ready;
  assign in_ready = (r_state == IDLE) && w_drain_ok;
  assign w_accept = in_valid && in_ready;
  assign w_start = w_accept && (op == OP_MUL);
  assign w_load_alu = w_accept && (op != OP_MUL);
  assign w_load_mul = ((r_state == MUL && w_done) || r_state == HOLD) && w_drain_ok;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .i_start(w_start),
    .i_step(r_state == MUL),
    .i_a(w_a),
    .i_b(w_b),
    .o_done(w_done),
    .o_prod(w_prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_out_valid <= 1'b0;
      r_out <= '0;
      r_ofl <= 1'b0;
      r_zero <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_load_alu) begin
        r_out <= w_res;
        r_ofl <= w_ofl;
        r_zero <= w_res == '0;
        r_err <= op > OP_LAST_LEGAL;
      end else if (w_load_mul) begin
        r_out <= w_prod[WIDTH-1:0];
        r_ofl <= |w_prod[2*WIDTH-1:WIDTH];
        r_zero <= w_prod[WIDTH-1:0] == '0;
        r_err <= 1'b0;
      end
      r_out_valid <= w_load_alu || w_load_mul || (r_out_valid && !out_ready);
      r_state <= w_start ? MUL : w_load_mul ? IDLE : (r_state == MUL && w_done) ? HOLD : r_state;
    end
  end
  assign out_valid = r_out_valid;
  assign out = r_out;
  assign ofl = r_ofl;
  assign zero = r_zero;
  assign err = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 16;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, inv_a = 0, inv_b = 0, sign = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic in_ready, out_valid, ofl, zero, err;
  logic [W-1:0] out;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .op(op), .inv_a(inv_a), .inv_b(inv_b), .sign(sign), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ofl(ofl), .zero(zero), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] model(input logic [3:0] o, input logic [15:0] ai, bi, input logic c, ia, ib, sg);
    logic [15:0] xa, xb;
    int A, B, sh, sa, sb, ci, s, r, f, e;
    longint p;
    xa = ia ? ~ai : ai;
    xb = ib ? ~bi : bi;
    A = int'(xa);
    B = int'(xb);
    sh = B % 16;
    sa = A > 32767 ? A - 65536 : A;
    sb = B > 32767 ? B - 65536 : B;
    ci = c ? 1 : 0;
    r = 0; f = 0; e = 0;
    case (o)
      4'd0: r = (A << sh) | (A >> (16 - sh));
      4'd1: r = A << sh;
      4'd2: r = (A >> sh) | (A << (16 - sh));
      4'd3: r = sa >>> sh;
      4'd4: begin
        s = A + B + ci;
        r = s;
        f = sg ? int'((sa + sb + ci) > 32767 || (sa + sb + ci) < -32768) : int'(s > 65535);
      end
      4'd5: r = A | B;
      4'd6: r = A ^ B;
      4'd7: r = A & B;
      4'd8: begin
        p = longint'(A) * longint'(B);
        r = int'(p % 65536);
        f = int'(p > 65535);
      end
      default: e = 1;
    endcase
    return {e[0], f[0], r[15:0]};
  endfunction
  task automatic send(input logic [3:0] o, input logic [15:0] av, bv, input logic c, ia, ib, sg);
    int n = 0;
    @(negedge clk);
    op = o; a = av; b = bv; cin = c; inv_a = ia; inv_b = ib; sign = sg; in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 100), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    a = W'($urandom); b = W'($urandom); op = 4'($urandom); cin = 1'($urandom);
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic [15:0] av, bv, input logic c, ia, ib, sg);
    logic [17:0] e;
    e = model(o, av, bv, c, ia, ib, sg);
    send(o, av, bv, c, ia, ib, sg);
    if (o == 4'd8) begin
      for (int k = 0; k < W; k++) begin
        chk({tag, ".busy"}, {30'd0, out_valid, in_ready}, 0);
        @(posedge clk);
        #1;
      end
    end
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".out"}, 32'(out), 32'(e[15:0]));
    chk({tag, ".ofl"}, 32'(ofl), 32'(e[16]));
    chk({tag, ".err"}, 32'(err), 32'(e[17]));
    chk({tag, ".zero"}, 32'(zero), 32'(e[15:0] == 16'd0));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] o;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.flags", {28'd0, out != 0, ofl, zero, err}, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 1);
    run("sra", 4'd3, 16'hFA7B, 16'd4, 0, 0, 0, 0);
    chk("sra.const", 32'(out), 32'hFFA7);
    run("add_s", 4'd4, 16'd20000, 16'd20000, 0, 0, 0, 1);
    chk("add_s.const", {15'd0, ofl, out}, {15'd0, 1'b1, 16'h9C40});
    run("add_u", 4'd4, 16'd20000, 16'd20000, 0, 0, 0, 0);
    chk("add_u.ofl", 32'(ofl), 0);
    run("mul", 4'd8, 16'd300, 16'd300, 1, 0, 0, 1);
    chk("mul.const", {15'd0, ofl, out}, {15'd0, 1'b1, 16'h5F90});
    @(negedge clk);
    out_ready = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mul.hold", {14'd0, in_ready, out_valid, out}, {14'd0, 1'b0, 1'b1, 16'h5F90});
    end
    @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    run("bp1", 4'd4, 16'd1, 16'd2, 0, 0, 0, 0);
    @(negedge clk);
    op = 4'd4; a = 16'd5; b = 16'd5; cin = 0; inv_a = 0; inv_b = 0; in_valid = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp.stall", {14'd0, in_ready, out_valid, out}, {14'd0, 1'b0, 1'b1, 16'd3});
    end
    @(negedge clk);
    out_ready = 1;
    #1;
    chk("bp.ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("bp.swap", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd10});
    send(4'd8, 16'd300, 16'd300, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rstmul.valid", {15'd0, out_valid, out}, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rstmul.in_ready", 32'(in_ready), 1);
    for (int k = 0; k < W + 2; k++) begin
      chk("rstmul.quiet", 32'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    run("add0", 4'd4, 16'd0, 16'd0, 0, 0, 0, 0);
    chk("add0.zero", {15'd0, zero, out}, {15'd0, 1'b1, 16'd0});
    run("ill", 4'd12, 16'h1234, 16'h5678, 1, 0, 0, 1);
    chk("ill.const", {13'd0, err, zero, ofl, out}, {13'd0, 1'b1, 1'b1, 1'b0, 16'd0});
    run("rol0", 4'd0, 16'h8001, 16'h0010, 0, 0, 0, 0);
    run("ror_inv", 4'd2, 16'h00F1, 16'hFFFE, 0, 1, 1, 0);
    run("add_cin", 4'd4, 16'h8000, 16'h8000, 1, 0, 0, 1);
    for (int i = 0; i < 150; i++) begin
      o = ($urandom_range(0, 4) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      run("rnd", o, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU that succeeds the 16-bit combinational ALU in the execute stage. It keeps the eight single-cycle operations (rotate/shift, add, OR/XOR/AND) with operand inversion and signed/unsigned overflow, generalised to `WIDTH` bits. It adds a registered output with valid/ready flow control and an iterative unsigned multiply. The decode/issue logic feeds it, and writeback drains it.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: operation accepted on edge where `in_valid && in_ready`.
- `a`, `b` input WIDTH: operands.
- `cin` input 1: carry-in (ADD only).
- `op` input 4: opcode, encodings in `alu_pkg`.
- `inv_a`, `inv_b` input 1: bitwise-invert operand before the operation.
- `sign` input 1: overflow mode, 1 = signed, 0 = unsigned.
- `out_valid` output 1: result register holds an undelivered result.
- `out_ready` input 1: consumer takes result on edge where `out_valid && out_ready`.
- `out` output WIDTH: result.
- `ofl` output 1: overflow flag.
- `zero` output 1: `out == 0`.
- `err` output 1: illegal opcode.

## Operation
- Opcodes: 0 ROL, 1 SLL, 2 ROR, 3 SRA, 4 ADD, 5 OR, 6 XOR, 7 AND, 8 MUL. Values 9–15 are illegal.
- Operand inversion applies first, giving A' and B'. The shift amount is `B'[SHW-1:0]`. Shift amount 0 returns A' unchanged.
- SRA replicates `A'[WIDTH-1]`.
- ADD: `out = A'+B'+cin` mod 2^WIDTH.
  - `sign=1`: `ofl` = operand signs equal and result sign differs.
  - `sign=0`: `ofl` = carry-out.
- MUL: unsigned shift-add, one partial product per cycle. `out` = low WIDTH bits of the product. `ofl` = high WIDTH bits nonzero, independent of `sign`; `cin` is ignored.
- `ofl` = 0 for shifts and logic ops.
- Illegal op: `out=0`, `zero=1`, `ofl=0`, `err=1`. The result is delivered through the normal handshake.
- State machine:
  - IDLE: accepts an operation.
    - Single-cycle op: the result register loads on the accept edge, and the state stays IDLE.
    - MUL: latches A', B', clears the accumulator, sets `cnt=0`, and goes to MUL.
  - MUL: each cycle adds `B'<<cnt` to the 2·WIDTH accumulator when `A'[cnt]=1`, then increments `cnt`.
    - When `cnt==WIDTH-1`, the final add is performed and the result register loads on that edge, but only if the register is empty or draining this cycle. Otherwise the state goes to HOLD.
  - HOLD: the result register loads on the first edge it is empty or draining, then the state returns to IDLE.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
- Result register: `out`, `ofl`, `zero`, `err`, `out_valid`.
  - On any edge with no load, the result register is unchanged.
  - `out_valid` clears on a drain edge unless a load happens on the same edge.
- Reset, including mid-MUL: state IDLE, `cnt=0`, `out_valid=0`, `out=0`, `ofl=0`, `zero=0`, `err=0`. `in_ready` is 1 in the cycle after reset deasserts.

## Timing
- Single-cycle ops: accepted at edge N, `out_valid` is high from N+1.
- Back-to-back throughput is 1 op per cycle while `out_ready=1`.
- MUL:
  - accepted at edge N;
  - result loads at edge N+WIDTH, so latency is WIDTH cycles;
  - `in_ready` is 0 from N+1 until the edge that returns to IDLE.
- Simultaneous drain and load on one edge: the new result replaces the old one, and `out_valid` stays 1.
- When `out_ready=0` with `out_valid=1`: `in_ready=0`, and all outputs hold stable.
- Inputs `a`, `b`, `op`, `cin`, `inv_*`, `sign` are sampled only on the accept edge. They are don't-care otherwise.

## Structure
- `alu_pkg`:
  - the opcode localparams (`OP_ROL`…`OP_MUL`);
  - the state enum (IDLE, MUL, HOLD);
  - `OP_LAST_LEGAL`.
- Sub-module `alu_mul_seq` holds the MUL datapath: operand latches, accumulator, `cnt`, and done pulse. The top owns the FSM, the combinational single-cycle datapath, and the result register.

## Test plan
- SRA, WIDTH=16: a=0xFA7B, b=4, `in_valid` for one cycle → next cycle `out=0xFFA7`, `out_valid=1`, `ofl=0`, `err=0`.
- Signed ADD overflow: a=b=20000, `sign=1` → `out=0x9C40`, `ofl=1`, `zero=0`. Repeat with `sign=0`: → `ofl=0`.
- MUL: a=b=300 → `out=0x5F90`, `ofl=1`. `out_valid` rises exactly 16 cycles after accept, and `in_ready=0` throughout.
- Backpressure: `out_ready=0`, issue ADD 1+2, then present ADD 5+5 → `in_ready=0`, `out=3` stays stable. Raising `out_ready` for one cycle delivers 3 and accepts 5+5 on the same edge, and `out=10` follows.
- Reset mid-MUL: assert `rst` at MUL iteration 5 → next cycle `out_valid=0`, `in_ready=1`. A following ADD 0+0 gives `out=0`, `zero=1`.
- Illegal op 12 with a=0x1234 → `out=0`, `err=1`, `zero=1`, delivered after 1 cycle.
